key_dev: RTL and testbench
==========================

KEY_DEV -- requirements
Module: key_dev

Interface
REQ-001 Parameter DBITS, default 32, data and address bus width.
REQ-002 Parameter KDATAADDR, default 32'hFFFFF080, address of key data register KDATA.
REQ-003 Parameter KCTRLADDR, default 32'hFFFFF084, address of key control/status register KCTRL.
REQ-004 Parameter KEYBITS, default 4, number of push-buttons.
REQ-005 Parameter DEBOUNCE_CYCLES, default 500000, stable-cycle count required to accept a key change; minimum 2.
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 reset  input  1  reset, asynchronous, active-high.
REQ-008 ld  input  1  bus read strobe.
REQ-009 sw  input  1  bus write strobe.
REQ-010 addrbus  input  DBITS  bus address.
REQ-011 databus  inout  DBITS  shared data bus; driven only on a matching read, else high-impedance.
REQ-012 KEY  input  KEYBITS  raw push-buttons, active-low (0 = pressed), asynchronous to clk.
REQ-013 intr  output  1  level interrupt request to the processor.

Function
REQ-014 Each KEY bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Each key SHALL have its own debounce counter and debounced bit; debounced bit 1 = pressed, i.e. inverted synchronized KEY.
REQ-016 Counter SHALL clear to 0 on any cycle where the synchronized pressed value equals the debounced bit.
REQ-017 Counter SHALL increment on each cycle where they differ; on the edge the count would reach DEBOUNCE_CYCLES, the debounced bit SHALL take the new value and the counter SHALL clear.
REQ-018 A raw change held stable is therefore reflected in KDATA exactly 2+DEBOUNCE_CYCLES rising edges after the first edge sampling it; any glitch shorter than DEBOUNCE_CYCLES cycles is rejected.
REQ-019 KDATA SHALL be the KEYBITS debounced bits, zero-extended to DBITS on reads.
REQ-020 KCTRL bit0 = ready, bit2 = overrun, bit8 = IE; all other bits read 0.
REQ-021 Any debounced bit change (press or release, any key) SHALL set ready on that edge.
REQ-022 A change occurring while ready=1 and no KDATA read in the same cycle SHALL additionally set overrun.
REQ-023 A read of KDATA (ld=1, addrbus==KDATAADDR) SHALL clear ready on that edge, unless a change occurs in the same cycle, in which case ready stays 1 and overrun is not set.
REQ-024 Write to KCTRL (sw=1, addrbus==KCTRLADDR): bit8 loads IE; bit2=0 clears overrun, bit2=1 no effect; bit0 ignored (read-only).
REQ-025 Overrun set event and overrun-clear write in the same cycle: overrun SHALL remain 1.
REQ-026 Writes to KDATAADDR SHALL be ignored.
REQ-027 Read data SHALL be combinational: databus = selected register when ld=1 and address matches either register, else all z; reads have zero-cycle latency, side effects at the next edge.
REQ-028 intr SHALL equal IE AND ready, registered state only, no combinational path from bus inputs.
REQ-029 ld and sw asserted together to the same address: write effects and read side effects both apply.

Reset
REQ-030 On reset assertion, immediately and independent of clk: synchronizer flops = 1 (released), counters = 0, KDATA = 0, ready = 0, overrun = 0, IE = 0, intr = 0.
REQ-031 Reset mid-debounce SHALL discard the partial count; the key restarts debounce from the released state after reset deasserts.
REQ-032 databus SHALL be z during reset unless ld and address match, then read returns reset values.

Verification (DEBOUNCE_CYCLES=4, DBITS=32)
REQ-033 Reset, drive KEY=4'b1110 steady -> KDATA reads 32'h1 on edge 6 after first sample, KCTRL reads 32'h1; IE=0 so intr=0.
REQ-034 KEY[1] low for 3 cycles then high -> KDATA unchanged 0, ready stays 0.
REQ-035 Write KCTRL=32'h100, press KEY[2] -> intr rises with ready; read KDATA returns 32'h4, intr falls next edge.
REQ-036 Press KEY[0], do not read, release KEY[0] -> KCTRL reads 32'h5; write KCTRL=32'h100 -> reads 32'h101.
REQ-037 KDATA read in same cycle as a debounced change -> ready stays 1, overrun stays 0.
REQ-038 Assert reset with IE=1, ready=1, overrun=1 -> intr and all KCTRL bits 0 without a clock edge; databus z when ld=0.

Source files
------------

// File: rtl/key_dev.sv
// Debounced push-button device with memory-mapped data/status registers.
// Raises a level interrupt when a debounced key change is pending and IE is set.
module key_dev #(
  parameter int             DBITS           = 32,
  parameter logic [DBITS-1:0] KDATAADDR     = 32'hFFFFF080,
  parameter logic [DBITS-1:0] KCTRLADDR     = 32'hFFFFF084,
  parameter int             KEYBITS         = 4,
  parameter int             DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld,
  input  logic               sw,
  input  logic [DBITS-1:0]   addrbus,
  inout  wire  [DBITS-1:0]   databus,
  input  logic [KEYBITS-1:0] KEY,
  output logic               intr
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [KEYBITS-1:0] sync1;
  logic [KEYBITS-1:0] sync2;
  logic [KEYBITS-1:0] pressed;
  logic [KEYBITS-1:0] deb;
  logic [KEYBITS-1:0] flip;
  logic [CW-1:0]      cnt [KEYBITS];
  logic               change;
  logic               ready;
  logic               overrun;
  logic               ie;
  logic               rd_data;
  logic               rd_ctrl;
  logic               wr_ctrl;
  logic [DBITS-1:0]   rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;

  // A key flips on the edge its mismatch count would reach the threshold.
  always_comb begin
    flip = '0;
    for (int i = 0; i < KEYBITS; i++) begin
      flip[i] = (pressed[i] != deb[i]) && (cnt[i] == LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < KEYBITS; i++) begin
        cnt[i] <= '0;
      end
      deb <= '0;
    end else begin
      for (int i = 0; i < KEYBITS; i++) begin
        if ((pressed[i] == deb[i]) || flip[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      deb <= deb ^ flip;
    end
  end

  assign change  = |flip;
  assign rd_data = ld && (addrbus == KDATAADDR);
  assign rd_ctrl = ld && (addrbus == KCTRLADDR);
  assign wr_ctrl = sw && (addrbus == KCTRLADDR);

  // A fresh change wins over a simultaneous read or overrun-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready   <= 1'b0;
      overrun <= 1'b0;
      ie      <= 1'b0;
    end else begin
      ready   <= change | (ready & ~rd_data);
      overrun <= (change & ready & ~rd_data)
               | (overrun & ~(wr_ctrl & ~databus[2]));
      if (wr_ctrl) begin
        ie <= databus[8];
      end
    end
  end

  assign intr = ie & ready;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      rd_data: rdata[KEYBITS-1:0] = deb;
      rd_ctrl: begin
        rdata[0] = ready;
        rdata[2] = overrun;
        rdata[8] = ie;
      end
      default: rdata = '0;
    endcase
  end

  assign databus = (rd_data || rd_ctrl) ? rdata : {DBITS{1'bz}};

endmodule

// File: tb/tb_key_dev.sv
// Bench for key_dev: directed scenarios plus randomized traffic against a
// sliding-window debounce model.
module tb_key_dev;

  localparam int D = 4;
  localparam logic [31:0] KDA = 32'hFFFFF080;
  localparam logic [31:0] KCA = 32'hFFFFF084;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld = 1'b0;
  logic        sw = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  key = 4'hF;
  logic        intr;
  wire  [31:0] databus;

  int tests = 0;
  int fails = 0;

  assign databus = wen ? wdata : 32'hzzzzzzzz;
  pullup (databus);

  key_dev #(
    .DBITS(32),
    .KDATAADDR(KDA),
    .KCTRLADDR(KCA),
    .KEYBITS(4),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ld(ld),
    .sw(sw),
    .addrbus(addr),
    .databus(databus),
    .KEY(key),
    .intr(intr)
  );

  always #5 clk = ~clk;

  // Model: a key's debounced value flips once the last D values it was
  // shown (after the 2-stage sync delay) all disagree with it.
  logic [3:0] mq1, mq2, mdeb, mflip;
  logic [3:0] mhist [D-1];
  logic       mready, movr, mie;
  logic       mrd, mwc;

  assign mrd = ld && (addr == KDA);
  assign mwc = sw && (addr == KCA);

  always_comb begin
    mflip = '0;
    for (int i = 0; i < 4; i++) begin
      mflip[i] = (mq2[i] != mdeb[i]);
      for (int k = 0; k < D-1; k++) begin
        if (mhist[k][i] == mdeb[i]) mflip[i] = 1'b0;
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq1 <= '0;
      mq2 <= '0;
      mdeb <= '0;
      for (int k = 0; k < D-1; k++) mhist[k] <= '0;
      mready <= 1'b0;
      movr <= 1'b0;
      mie <= 1'b0;
    end else begin
      mq1 <= ~key;
      mq2 <= mq1;
      mhist[0] <= mq2;
      for (int k = 1; k < D-1; k++) mhist[k] <= mhist[k-1];
      mdeb <= mdeb ^ mflip;
      mready <= (|mflip) ? 1'b1 : (mrd ? 1'b0 : mready);
      movr <= ((|mflip) && mready && !mrd) ? 1'b1
            : ((mwc && !wdata[2]) ? 1'b0 : movr);
      if (mwc) mie <= wdata[8];
    end
  end

  function automatic logic [31:0] mkctrl();
    logic [31:0] v;
    v = '0;
    v[0] = mready;
    v[2] = movr;
    v[8] = mie;
    return v;
  endfunction

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    ld = 1'b0;
    sw = 1'b0;
    wen = 1'b0;
    key = 4'hF;
    wait_edges(2);
    reset = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] v);
    ld = 1'b1;
    addr = a;
    #1 v = databus;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    sw = 1'b1;
    wen = 1'b1;
    addr = a;
    wdata = d;
    @(negedge clk);
    sw = 1'b0;
    wen = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    apply_reset();
    tests++;
    if (intr !== 1'b0) begin
      fails++;
      $display("FAIL reset_intr: got %b want 0", intr);
    end
    do_read(KDA, v);
    tests++;
    if (v !== 32'h0) begin
      fails++;
      $display("FAIL reset_kdata: got %h want 0", v);
    end
    do_read(KCA, v);
    tests++;
    if (v !== 32'h0) begin
      fails++;
      $display("FAIL reset_kctrl: got %h want 0", v);
    end
  endtask

  task automatic test_press_latency();
    logic [31:0] v;
    apply_reset();
    key = 4'hE;
    wait_edges(4);
    do_read(KDA, v);
    tests++;
    if (v !== 32'h0) begin
      fails++;
      $display("FAIL press_edge4_kdata: got %h want 0", v);
    end
    do_read(KCA, v);
    tests++;
    if (v !== 32'h0) begin
      fails++;
      $display("FAIL press_edge5_kctrl: got %h want 0", v);
    end
    do_read(KCA, v);
    tests++;
    if (v !== 32'h1 || intr !== 1'b0) begin
      fails++;
      $display("FAIL press_edge6_kctrl: got %h intr %b want 1 intr 0",
               v, intr);
    end
    do_read(KDA, v);
    tests++;
    if (v !== 32'h1) begin
      fails++;
      $display("FAIL press_kdata: got %h want 1", v);
    end
    do_read(KCA, v);
    tests++;
    if (v !== 32'h0) begin
      fails++;
      $display("FAIL press_read_clears: got %h want 0", v);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] v;
    apply_reset();
    key = 4'hD;
    wait_edges(3);
    key = 4'hF;
    wait_edges(8);
    do_read(KDA, v);
    tests++;
    if (v !== 32'h0) begin
      fails++;
      $display("FAIL glitch3_kdata: got %h want 0", v);
    end
    do_read(KCA, v);
    tests++;
    if (v !== 32'h0) begin
      fails++;
      $display("FAIL glitch3_kctrl: got %h want 0", v);
    end
    // Exactly D cycles low is accepted, then released while still ready.
    key = 4'hD;
    wait_edges(4);
    key = 4'hF;
    wait_edges(10);
    do_read(KCA, v);
    tests++;
    if (v !== 32'h5) begin
      fails++;
      $display("FAIL pulse4_kctrl: got %h want 5", v);
    end
  endtask

  task automatic test_intr();
    logic [31:0] v;
    apply_reset();
    do_write(KCA, 32'h100);
    tests++;
    if (intr !== 1'b0) begin
      fails++;
      $display("FAIL intr_idle: got %b want 0", intr);
    end
    key = 4'hB;
    wait_edges(5);
    tests++;
    if (intr !== 1'b0) begin
      fails++;
      $display("FAIL intr_early: got %b want 0", intr);
    end
    wait_edges(1);
    tests++;
    if (intr !== 1'b1) begin
      fails++;
      $display("FAIL intr_rise: got %b want 1", intr);
    end
    do_read(KDA, v);
    tests++;
    if (v !== 32'h4 || intr !== 1'b0) begin
      fails++;
      $display("FAIL intr_ack: kdata %h intr %b want 4 intr 0", v, intr);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] v;
    apply_reset();
    key = 4'hE;
    wait_edges(8);
    key = 4'hF;
    wait_edges(8);
    do_read(KCA, v);
    tests++;
    if (v !== 32'h5) begin
      fails++;
      $display("FAIL overrun_kctrl: got %h want 5", v);
    end
    do_write(KCA, 32'h100);
    do_read(KCA, v);
    tests++;
    if (v !== 32'h101 || intr !== 1'b1) begin
      fails++;
      $display("FAIL overrun_clear: got %h intr %b want 101 intr 1",
               v, intr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    apply_reset();
    key = 4'h7;
    wait_edges(5);
    do_read(KDA, v);
    do_read(KCA, v);
    tests++;
    if (v !== 32'h1) begin
      fails++;
      $display("FAIL read_collide: got %h want 1", v);
    end
    key = 4'hF;
    wait_edges(5);
    do_write(KCA, 32'h0);
    do_read(KCA, v);
    tests++;
    if (v !== 32'h5) begin
      fails++;
      $display("FAIL set_beats_clear: got %h want 5", v);
    end
    do_write(KDA, 32'hF);
    do_read(KDA, v);
    tests++;
    if (v !== 32'h0) begin
      fails++;
      $display("FAIL kdata_write_ignored: got %h want 0", v);
    end
    do_write(KCA, 32'h4);
    do_read(KCA, v);
    tests++;
    if (v !== 32'h4) begin
      fails++;
      $display("FAIL ovr_bit2_hold: got %h want 4", v);
    end
    do_write(KCA, 32'h1);
    do_read(KCA, v);
    tests++;
    if (v !== 32'h0) begin
      fails++;
      $display("FAIL ovr_clear_ro_ready: got %h want 0", v);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    apply_reset();
    do_write(KCA, 32'h100);
    key = 4'hE;
    wait_edges(8);
    key = 4'hF;
    wait_edges(8);
    tests++;
    if (intr !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_intr: got %b want 1", intr);
    end
    key = 4'hD;
    wait_edges(3);
    #2 reset = 1'b1;
    #1;
    tests++;
    if (intr !== 1'b0) begin
      fails++;
      $display("FAIL async_intr: got %b want 0", intr);
    end
    ld = 1'b1;
    addr = KCA;
    #1;
    tests++;
    if (databus !== 32'h0) begin
      fails++;
      $display("FAIL async_kctrl: got %h want 0", databus);
    end
    ld = 1'b0;
    #1;
    tests++;
    if (databus !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL reset_bus_release: got %h want undriven", databus);
    end
    wait_edges(2);
    reset = 1'b0;
    wait_edges(5);
    do_read(KCA, v);
    tests++;
    if (v !== 32'h0) begin
      fails++;
      $display("FAIL restart_early: got %h want 0", v);
    end
    do_read(KCA, v);
    tests++;
    if (v !== 32'h1) begin
      fails++;
      $display("FAIL restart_full: got %h want 1", v);
    end
  endtask

  task automatic test_random();
    int op;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) == 0) key = 4'($urandom);
      op = $urandom_range(0, 5);
      ld = (op == 2) || (op == 3);
      sw = (op == 4) || (op == 5);
      wen = sw;
      addr = (op == 2 || op == 5) ? KDA : KCA;
      wdata = $urandom & 32'h105;
      #1;
      tests++;
      if (intr !== (mie & mready)) begin
        fails++;
        $display("FAIL rand_intr c%0d: got %b want %b", c, intr,
                 mie & mready);
      end
      if (op == 2) begin
        tests++;
        if (databus !== {28'h0, mdeb}) begin
          fails++;
          $display("FAIL rand_kdata c%0d: got %h want %h", c, databus,
                   {28'h0, mdeb});
        end
      end else if (op == 3) begin
        tests++;
        if (databus !== mkctrl()) begin
          fails++;
          $display("FAIL rand_kctrl c%0d: got %h want %h", c, databus,
                   mkctrl());
        end
      end
      @(negedge clk);
      ld = 1'b0;
      sw = 1'b0;
      wen = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_glitch();
    test_intr();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
